apb_req_arbiter: RTL and testbench

- Shares the single APB bridge master-side transfer port (dsel/trnsfr/wr/address/data_in/data_out) among N_REQ independent requesters.
- Each requester gets exactly one outstanding transfer.
- Arbitration is round-robin, with a per-transfer timeout.
- Sits between the system's transfer initiators (DMA, CPU shim, config sequencer) and the bridge's master interface.

---
 rtl/apb_req_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_req_arbiter : round-robin sharing of one APB bridge transfer port
//                   among N_REQ requesters, with per-transfer WAIT timeout
// Revision 1.0
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          req_wr_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          done_o,
  output logic                      err_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      busy_o,
  output logic                      br_dsel,
  output logic                      br_trnsfr,
  output logic                      br_wr,
  output logic [ADDR_W-1:0]         br_address,
  output logic [DATA_W-1:0]         br_data_in,
  input  logic [DATA_W-1:0]         br_data_out,
  input  logic                      br_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q,  state_d;
  logic [IDX_W-1:0]    ptr_q,    ptr_d;
  logic [IDX_W-1:0]    win_q,    win_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                wr_q,     wr_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;
  logic                err_q,    err_d;
  logic [N_REQ-1:0]    gnt_q,    gnt_d;
  logic [N_REQ-1:0]    done_q,   done_d;
  logic                busy_q,   busy_d;
  logic                dsel_q,   dsel_d;
  logic                trnsfr_q, trnsfr_d;

  logic [IDX_W-1:0]    arb_idx;
  logic                arb_found;

  // First requester at or above the pointer, wrapping modulo N_REQ.
  always_comb begin
    int cand;
    arb_idx   = '0;
    arb_found = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!arb_found && req_i[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    gnt_d    = '0;
    done_d   = '0;
    busy_d   = busy_q;
    dsel_d   = dsel_q;
    trnsfr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d        = S_ISSUE;
          win_d          = arb_idx;
          wr_d           = req_wr_i[arb_idx];
          addr_d         = req_addr_i[arb_idx*ADDR_W +: ADDR_W];
          wdata_d        = req_wdata_i[arb_idx*DATA_W +: DATA_W];
          gnt_d[arb_idx] = 1'b1;
          busy_d         = 1'b1;
          dsel_d         = 1'b1;
          trnsfr_d       = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A completion on the last allowed cycle still counts as success.
        if (br_done) begin
          state_d       = S_RESP;
          done_d[win_q] = 1'b1;
          dsel_d        = 1'b0;
          if (!wr_q) rdata_d = br_data_out;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = S_RESP;
          done_d[win_q] = 1'b1;
          dsel_d        = 1'b0;
          err_d         = 1'b1;
          rdata_d       = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      dsel_q   <= 1'b0;
      trnsfr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      dsel_q   <= dsel_d;
      trnsfr_q <= trnsfr_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign br_dsel    = dsel_q;
  assign br_trnsfr  = trnsfr_q;
  assign br_wr      = wr_q;
  assign br_address = addr_q;
  assign br_data_in = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter : table vectors, directed corner sequences and random
//                      traffic checked against a transaction-level model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_i, req_wr_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    gnt_o, done_o;
  logic            err_o, busy_o, br_dsel, br_trnsfr, br_wr, br_done;
  logic [DW-1:0]   rdata_o, br_data_in, br_data_out;
  logic [AW-1:0]   br_address;

  apb_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_wr_i(req_wr_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .busy_o(busy_o), .br_dsel(br_dsel), .br_trnsfr(br_trnsfr), .br_wr(br_wr),
    .br_address(br_address), .br_data_in(br_data_in),
    .br_data_out(br_data_out), .br_done(br_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            bdelay;     // WAIT cycle carrying br_done; 0 = never
    logic [DW-1:0] bdata;
    logic [N-1:0]  exp_done;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_waits;
  } vec_t;
  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [N-1:0]  want;
  bit            rand_mode, rst_next, stale_bdone;
  int            next_bdelay;
  logic [DW-1:0] next_bdata;

  // Transaction-level model of the in-flight transfer
  bit            m_busy, m_err, m_wr;
  int            m_issue, m_W, m_done, m_free, m_win, m_ptr, m_bdelay;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_bdata, m_rdata;

  int            obs_count, obs_gnt_cycle, obs_done_cycle, trnsfr_count;
  logic [N-1:0]  obs_done;
  logic          obs_err;
  logic [DW-1:0] obs_rdata;
  int            gnt_order[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Pending requester with the smallest forward distance from the pointer.
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (r[i] && d < bestd) begin bestd = d; best = i; end
    end
    return best;
  endfunction

  task automatic step();
    logic [N-1:0] exp_gnt, exp_done, dropped;
    bit in_win, in_wait, at_done;
    @(negedge clk);
    cyc++;
    at_done = m_busy && cyc == m_done;
    if (at_done) begin
      if (m_err) m_rdata = '0;
      else if (!m_wr) m_rdata = m_bdata;
    end
    exp_gnt  = (m_busy && cyc == m_issue) ? onehot(m_win) : '0;
    exp_done = at_done ? onehot(m_win) : '0;
    in_win   = m_busy && cyc >= m_issue && cyc <= m_issue + m_W;
    chk("gnt_o", 64'(gnt_o), 64'(exp_gnt));
    chk("done_o", 64'(done_o), 64'(exp_done));
    chk("err_o", 64'(err_o), 64'(at_done && m_err));
    chk("rdata_o", 64'(rdata_o), 64'(m_rdata));
    chk("busy_o", 64'(busy_o), 64'(m_busy && cyc >= m_issue && cyc <= m_done));
    chk("br_dsel", 64'(br_dsel), 64'(in_win));
    chk("br_trnsfr", 64'(br_trnsfr), 64'(m_busy && cyc == m_issue));
    if (in_win) begin
      chk("br_wr", 64'(br_wr), 64'(m_wr));
      chk("br_address", 64'(br_address), 64'(m_addr));
      chk("br_data_in", 64'(br_data_in), 64'(m_wdata));
    end
    if (gnt_o != '0) begin obs_gnt_cycle = cyc; gnt_order.push_back(idx_of(gnt_o)); end
    if (br_trnsfr) trnsfr_count++;
    dropped = done_o;
    if (done_o != '0) begin
      obs_count++;
      obs_done_cycle = cyc;
      obs_done  = done_o;
      obs_err   = err_o;
      obs_rdata = rdata_o;
    end
    if (at_done) m_busy = 1'b0;

    if (rand_mode) begin
      want = want & ~dropped;
      for (int i = 0; i < N; i++) if (!want[i] && $urandom_range(3) == 0) want[i] = 1'b1;
      req_wr_i = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_addr_i[i*AW +: AW]  = $urandom;
        req_wdata_i[i*DW +: DW] = $urandom;
      end
    end
    req_i = want & ~dropped;

    in_wait = m_busy && cyc > m_issue && cyc <= m_issue + m_W;
    if (in_wait) begin
      br_done     = (cyc - m_issue == m_bdelay);
      br_data_out = m_bdata;
    end else begin
      br_done     = stale_bdone || (rand_mode && $urandom_range(7) == 0);
      br_data_out = $urandom;
    end

    rst = rst_next;
    if (rst_next) begin
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_rdata = '0;
      m_free  = cyc + 1;
    end else if (!m_busy && cyc >= m_free && req_i != '0) begin
      m_win   = rr_pick(req_i, m_ptr);
      m_issue = cyc + 1;
      if (rand_mode) begin
        case ($urandom_range(9))
          0:       m_bdelay = 0;
          1:       m_bdelay = TO;
          default: m_bdelay = $urandom_range(6, 1);
        endcase
        m_bdata = $urandom;
      end else begin
        m_bdelay = next_bdelay;
        m_bdata  = next_bdata;
      end
      m_err   = !(m_bdelay >= 1 && m_bdelay <= TO);
      m_W     = m_err ? TO : m_bdelay;
      m_done  = m_issue + m_W + 1;
      m_free  = m_done + 1;
      m_wr    = req_wr_i[m_win];
      m_addr  = req_addr_i[m_win*AW +: AW];
      m_wdata = req_wdata_i[m_win*DW +: DW];
      m_ptr   = (m_win + 1) % N;
      m_busy  = 1'b1;
    end
  endtask

  task automatic run_until_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (obs_count < target && k < budget) begin step(); k++; end
    chk({name, "_done_within_bound"}, 64'(obs_count >= target), 64'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tc0;
    int exp_order[9];
    vecs[0] = '{1, 1'b1, 32'h10, 32'hDEADBEEF, 3,  32'hAAAA5555, 4'b0010, 1'b0, 32'h0,        3};
    vecs[1] = '{2, 1'b0, 32'h20, 32'h0,        1,  32'h12345678, 4'b0100, 1'b0, 32'h12345678, 1};
    vecs[2] = '{0, 1'b1, 32'h30, 32'h01020304, 2,  32'h55555555, 4'b0001, 1'b0, 32'h12345678, 2};
    vecs[3] = '{3, 1'b0, 32'h40, 32'h0,        0,  32'hFFFFFFFF, 4'b1000, 1'b1, 32'h0,        16};
    vecs[4] = '{0, 1'b0, 32'h50, 32'h0,        16, 32'hCAFEF00D, 4'b0001, 1'b0, 32'hCAFEF00D, 16};
    vecs[5] = '{3, 1'b0, 32'h60, 32'h0,        5,  32'h0BADF00D, 4'b1000, 1'b0, 32'h0BADF00D, 5};
    exp_order = '{0, 1, 3, 0, 1, 2, 3, 0, 1};

    rst = 1'b1; req_i = '0; req_wr_i = '0; req_addr_i = '0; req_wdata_i = '0;
    br_done = 1'b0; br_data_out = '0;
    want = '0; rand_mode = 0; rst_next = 1; stale_bdone = 0;
    next_bdelay = 1; next_bdata = '0;
    m_busy = 0; m_ptr = 0; m_rdata = '0; m_free = 0; m_issue = 0; m_done = 0; m_W = 0;
    obs_count = 0; trnsfr_count = 0;

    step(); step();
    rst_next = 0;
    step();
    chk("reset_gnt", 64'(gnt_o), 64'(0));
    chk("reset_done", 64'(done_o), 64'(0));
    chk("reset_err", 64'(err_o), 64'(0));
    chk("reset_rdata", 64'(rdata_o), 64'(0));
    chk("reset_busy", 64'(busy_o), 64'(0));
    chk("reset_br_addr", 64'(br_address), 64'(0));

    // Single-requester transfers from the vector table
    for (int v = 0; v < 6; v++) begin
      base = obs_count;
      tc0  = trnsfr_count;
      req_wr_i[vecs[v].idx]              = vecs[v].wr;
      req_addr_i[vecs[v].idx*AW +: AW]   = vecs[v].addr;
      req_wdata_i[vecs[v].idx*DW +: DW]  = vecs[v].wdata;
      next_bdelay = vecs[v].bdelay;
      next_bdata  = vecs[v].bdata;
      want        = onehot(vecs[v].idx);
      run_until_done(base + 1, 60, "vec");
      want = '0;
      chk("vec_done_mask", 64'(obs_done), 64'(vecs[v].exp_done));
      chk("vec_err", 64'(obs_err), 64'(vecs[v].exp_err));
      chk("vec_rdata", 64'(obs_rdata), 64'(vecs[v].exp_rdata));
      chk("vec_wait_cycles", 64'(obs_done_cycle - obs_gnt_cycle - 1), 64'(vecs[v].exp_waits));
      chk("vec_trnsfr_pulses", 64'(trnsfr_count - tc0), 64'(1));
      step(); step(); step();
      chk("vec_rdata_hold", 64'(rdata_o), 64'(vecs[v].exp_rdata));
    end

    // Round-robin order, requester 2 joining mid-sequence
    rst_next = 1; step(); rst_next = 0;
    gnt_order.delete();
    base = obs_count;
    next_bdelay = 2; next_bdata = 32'h600DDA7A;
    want = 4'b1011;
    run_until_done(base + 5, 200, "rr_first");
    want[2] = 1'b1;
    run_until_done(base + 9, 200, "rr_second");
    want = '0;
    chk("rr_grant_count", 64'(gnt_order.size()), 64'(9));
    for (int i = 0; i < 9; i++)
      chk("rr_grant_order", 64'((i < gnt_order.size()) ? gnt_order[i] : -1), 64'(exp_order[i]));

    // Reset while in WAIT, stale br_done afterwards, then lowest pending wins
    step(); step();
    base = obs_count;
    next_bdelay = 0; next_bdata = 32'h0;
    req_wr_i[1] = 1'b0; req_addr_i[1*AW +: AW] = 32'h70;
    want = onehot(1);
    repeat (5) step();
    chk("rstwait_in_wait", 64'({br_dsel, br_trnsfr, busy_o}), 64'(3'b101));
    want = '0;
    rst_next = 1; step(); rst_next = 0;
    stale_bdone = 1; step(); stale_bdone = 0;
    chk("rstwait_gnt", 64'(gnt_o), 64'(0));
    chk("rstwait_busy", 64'(busy_o), 64'(0));
    chk("rstwait_dsel", 64'(br_dsel), 64'(0));
    chk("rstwait_addr", 64'(br_address), 64'(0));
    chk("rstwait_done", 64'(done_o), 64'(0));
    repeat (4) step();
    chk("rstwait_no_done", 64'(obs_count), 64'(base));
    gnt_order.delete();
    next_bdelay = 1; next_bdata = 32'h13572468;
    want = 4'b1100;
    run_until_done(base + 1, 60, "rstwait_after");
    want = '0;
    chk("rstwait_first_grant", 64'(obs_done), 64'(4'b0100));
    repeat (30) step();

    // Random traffic against the model
    rst_next = 1; step(); rst_next = 0;
    rand_mode = 1;
    repeat (2000) step();
    rand_mode = 0;
    want = '0;
    for (int k = 0; k < 40 && m_busy; k++) step();
    chk("random_drained", 64'(m_busy), 64'(0));
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
